// File: rtl/gsim_mem_resp_if.sv
// Solver-side read handshake plus preload port of the gsim_mem_resp row store.
interface gsim_mem_resp_if;
  logic         i_mem_rreq;
  logic [9:0]   i_mem_addr;
  logic         o_mem_rrdy;
  logic [255:0] o_mem_dout;
  logic         o_mem_dout_vld;
  logic         i_ld_wen;
  logic [9:0]   i_ld_addr;
  logic [255:0] i_ld_data;
  logic         o_busy;

  modport master (
    output i_mem_rreq, i_mem_addr, i_ld_wen, i_ld_addr, i_ld_data,
    input  o_mem_rrdy, o_mem_dout, o_mem_dout_vld, o_busy
  );

  modport slave (
    input  i_mem_rreq, i_mem_addr, i_ld_wen, i_ld_addr, i_ld_data,
    output o_mem_rrdy, o_mem_dout, o_mem_dout_vld, o_busy
  );
endinterface

// File: rtl/gsim_mem_resp.sv
// 1024 x 256-bit row store with fixed-latency read pipeline and periodic
// ready-stall injection, used to exercise a solver's memory handshake.
module gsim_mem_resp #(
  parameter int READ_LAT     = 2,
  parameter int STALL_PERIOD = 8,
  parameter int STALL_LEN    = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  gsim_mem_resp_if.slave  mem
);

  localparam int CW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST    = (STALL_PERIOD > 0) ? CW'(STALL_PERIOD - 1) : '0;
  localparam logic [CW-1:0] STALL_FIRST = (STALL_PERIOD > 0) ? CW'(STALL_PERIOD - STALL_LEN) : '0;

  logic [255:0]        mem_q [1024];
  logic [CW-1:0]       stall_cnt_q, stall_cnt_d;
  logic                in_stall;
  logic                accept;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [255:0]        data_q [READ_LAT];
  logic [255:0]        data_d [READ_LAT];

  assign in_stall       = (STALL_PERIOD != 0) && (stall_cnt_q >= STALL_FIRST);
  assign mem.o_mem_rrdy = !i_reset && !mem.i_ld_wen && !in_stall;
  assign accept         = mem.i_mem_rreq && mem.o_mem_rrdy;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 1'b1;
    if (STALL_PERIOD == 0 || stall_cnt_q == CNT_LAST) begin
      stall_cnt_d = '0;
    end
  end

  // Data stages only advance behind a valid bit, so the last stage keeps the
  // most recent returned row through bubbles.
  always_comb begin
    vld_d = '0;
    for (int k = 0; k < READ_LAT; k++) begin
      data_d[k] = data_q[k];
    end
    vld_d[0] = accept;
    if (accept) begin
      data_d[0] = mem_q[mem.i_mem_addr];
    end
    for (int k = 1; k < READ_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      vld_q       <= '0;
      for (int k = 0; k < READ_LAT; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      stall_cnt_q <= stall_cnt_d;
      vld_q       <= vld_d;
      for (int k = 0; k < READ_LAT; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // Array is not reset; the read above samples it before this edge's write.
  always_ff @(posedge i_clk) begin
    if (mem.i_ld_wen) begin
      mem_q[mem.i_ld_addr] <= mem.i_ld_data;
    end
  end

  assign mem.o_mem_dout_vld = !i_reset && vld_q[READ_LAT-1];
  assign mem.o_mem_dout     = i_reset ? '0 : data_q[READ_LAT-1];
  assign mem.o_busy         = !i_reset && (|vld_q);

endmodule

// File: tb/tb_gsim_mem_resp.sv
// Scoreboard bench for gsim_mem_resp: two instances (default params, and
// READ_LAT=1 with stalls disabled) driven by directed sequences.
module tb_gsim_mem_resp;

  typedef struct packed {
    int unsigned  acc;
    int unsigned  due;
    logic [255:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  logic         rst     [2];
  logic         rreq    [2];
  logic [9:0]   addr    [2];
  logic         ld_wen  [2];
  logic [9:0]   ld_addr [2];
  logic [255:0] ld_data [2];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int a, input int s);
    logic [255:0] d;
    for (int l = 0; l < 16; l++) d[16*l +: 16] = 16'(a * 16 + l + s);
    return d;
  endfunction

  // Inputs are set at a falling edge and held until the next falling edge.
  task automatic drv(input int g, input bit r, input bit rq, input int a,
                     input bit w, input int la, input logic [255:0] ld);
    rst[g]     = r;
    rreq[g]    = rq;
    addr[g]    = 10'(a);
    ld_wen[g]  = w;
    ld_addr[g] = 10'(la);
    ld_data[g] = ld;
    @(negedge clk);
  endtask

  task automatic idle(input int g, input int n);
    repeat (n) drv(g, 0, 0, 0, 0, 0, '0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : 1;
    localparam int SP  = (g == 0) ? 8 : 0;
    localparam int SL  = (g == 0) ? 2 : 0;

    gsim_mem_resp_if ifc ();
    assign ifc.i_mem_rreq = rreq[g];
    assign ifc.i_mem_addr = addr[g];
    assign ifc.i_ld_wen   = ld_wen[g];
    assign ifc.i_ld_addr  = ld_addr[g];
    assign ifc.i_ld_data  = ld_data[g];

    gsim_mem_resp #(.READ_LAT(LAT), .STALL_PERIOD(SP), .STALL_LEN(SL)) dut (
      .i_clk   (clk),
      .i_reset (rst[g]),
      .mem     (ifc.slave)
    );

    logic [255:0] mmem [1024];
    exp_t         sbq [$];
    int           mcnt  = 0;
    logic [255:0] mlast = '0;
    bit           mr, ev, eb;

    // Stimulus side: predict ready, queue expected rows, update shadow array.
    initial forever begin
      @(negedge clk);
      #1;
      mr = !rst[g] && !ld_wen[g] && !(SP != 0 && mcnt >= SP - SL);
      chk($sformatf("dut%0d rrdy c%0d", g, cyc), 256'(ifc.o_mem_rrdy), 256'(mr));
      if (mr && rreq[g]) sbq.push_back('{cyc, cyc + LAT, mmem[addr[g]]});
      if (ld_wen[g]) mmem[ld_addr[g]] = ld_data[g];
      if (rst[g]) begin
        sbq.delete();
        mlast = '0;
      end
      if (rst[g] || SP == 0 || mcnt == SP - 1) mcnt = 0;
      else mcnt = mcnt + 1;
    end

    // Output side: compare whatever the DUT presents against the queue head.
    initial forever begin
      @(negedge clk);
      #2;
      ev = !rst[g] && sbq.size() > 0 && sbq[0].due == cyc;
      eb = !rst[g] && sbq.size() > 0 && sbq[0].acc < cyc;
      chk($sformatf("dut%0d vld c%0d", g, cyc), 256'(ifc.o_mem_dout_vld), 256'(ev));
      chk($sformatf("dut%0d busy c%0d", g, cyc), 256'(ifc.o_busy), 256'(eb));
      if (ev) begin
        chk($sformatf("dut%0d dout c%0d", g, cyc), ifc.o_mem_dout, sbq[0].data);
        mlast = sbq[0].data;
        void'(sbq.pop_front());
      end else begin
        chk($sformatf("dut%0d hold c%0d", g, cyc), ifc.o_mem_dout, mlast);
      end
    end
  end

  initial begin
    int a;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; rreq[g] = 1'b0; addr[g] = '0;
      ld_wen[g] = 1'b0; ld_addr[g] = '0; ld_data[g] = '0;
    end

    // Instance 0: READ_LAT=2, STALL_PERIOD=8, STALL_LEN=2
    repeat (3) drv(0, 1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 32; i++)
      drv(0, 0, 0, 0, 1, i, (i == 5) ? 256'h0001_0002 : pat(i, 0));

    // single read of row 5 (lane0=2, lane1=1)
    drv(0, 1, 0, 0, 0, 0, '0);
    idle(0, 2);
    drv(0, 0, 1, 5, 0, 0, '0);
    idle(0, 4);

    // stream with rreq held high; address advances on counter phases 0..5
    drv(0, 1, 0, 0, 0, 0, '0);
    a = 0;
    for (int i = 0; i < 24; i++) begin
      drv(0, 0, 1, a, 0, 0, '0);
      if (i % 8 < 6) a++;
    end
    idle(0, 4);

    // preload collision, then write behind an in-flight read
    drv(0, 1, 0, 0, 0, 0, '0);
    drv(0, 0, 1, 7, 1, 7, pat(7, 1000));
    drv(0, 0, 1, 7, 0, 0, '0);
    drv(0, 0, 1, 3, 0, 0, '0);
    drv(0, 0, 0, 0, 1, 3, pat(3, 2000));
    idle(0, 4);
    drv(0, 0, 1, 3, 0, 0, '0);
    idle(0, 4);

    // reset flushes two in-flight reads
    drv(0, 1, 0, 0, 0, 0, '0);
    drv(0, 0, 1, 1, 0, 0, '0);
    drv(0, 0, 1, 2, 0, 0, '0);
    drv(0, 1, 0, 0, 0, 0, '0);
    idle(0, 6);
    drv(0, 1, 0, 0, 0, 0, '0);

    // Instance 1: READ_LAT=1, stalls disabled, full-array back-to-back sweep
    repeat (2) drv(1, 1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 1024; i++) drv(1, 0, 0, 0, 1, i, pat(i, 7));
    for (int i = 0; i < 1024; i++) drv(1, 0, 1, i, 0, 0, '0);
    idle(1, 4);
    drv(1, 1, 0, 0, 0, 0, '0);
    idle(1, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    errs++;
    $display("FAIL watchdog: stopped at cycle %0d, expected finish before cycle 100000", cyc);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
